// File: rtl/spi_shift_engine_pkg.sv
// Shared SPI types for the ILI9341 display link: FSM state encoding,
// per-transfer configuration and the four standard SPI mode constants.
package pkg_ili9341;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_cfg_t;

    localparam spi_cfg_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0, lsb_first: 1'b0};
    localparam spi_cfg_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1, lsb_first: 1'b0};
    localparam spi_cfg_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0, lsb_first: 1'b0};
    localparam spi_cfg_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1, lsb_first: 1'b0};

endpackage

// File: rtl/spi_shift_engine_clk_div.sv
// SCLK half-period timer: emits a one-cycle tick every CLK_DIV enabled cycles.
// Clearing restarts the period so the first SCLK edge is aligned to the accept.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: variable word length, all four CPOL/CPHA modes,
// MSB/LSB order, generated SCLK and CS, start/done handshake.
module spi_shift_engine
    import pkg_ili9341::*;
#(
    parameter int DW      = 8,
    parameter int CLK_DIV = 4,
    parameter int LW      = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cpol,
    input  logic          cpha,
    input  logic          lsb_first,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] tx_data,
    input  logic          miso,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rx_data,
    output logic          sclk,
    output logic          mosi,
    output logic          cs_n
);

    // Handshake: start is taken only in IDLE (busy=0); done pulses for one
    // cycle with busy already low, so start in that cycle is accepted.
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SETUP = SETUP;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_HOLD  = HOLD;

    localparam logic [LW-1:0] LEN_MAX = LW'(DW);

    logic [1:0]    state_q, state_d;
    spi_cfg_t      cfg_q, cfg_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] bit_cnt_q, bit_cnt_d;
    logic          lead_q, lead_d;
    logic [DW-1:0] tx_sh_q, tx_sh_d;
    logic [DW-1:0] rx_sh_q, rx_sh_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;

    logic          accept;
    logic          tick;
    logic [LW-1:0] len_eff;
    logic [DW-1:0] tx_aligned;

    function automatic logic head_bit(input logic [DW-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DW-1];
    endfunction

    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] w, input logic b,
                                               input logic lsb);
        return lsb ? {b, w[DW-1:1]} : {w[DW-2:0], b};
    endfunction

    // MSB-first words are left-justified so the head bit is always w[DW-1].
    assign len_eff    = (len == '0 || len > LEN_MAX) ? LEN_MAX : len;
    assign tx_aligned = lsb_first ? tx_data : (tx_data << (LEN_MAX - len_eff));

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q != S_IDLE),
        .clr_i (accept),
        .tick_o(tick)
    );

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        lead_d    = lead_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        accept    = 1'b0;

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b1;
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    accept          = 1'b1;
                    state_d         = S_SETUP;
                    cfg_d.cpol      = cpol;
                    cfg_d.cpha      = cpha;
                    cfg_d.lsb_first = lsb_first;
                    len_d           = len_eff;
                    bit_cnt_d       = '0;
                    lead_d          = 1'b1;
                    rx_sh_d         = '0;
                    busy_d          = 1'b1;
                    cs_n_d          = 1'b0;
                    if (!cpha) begin
                        mosi_d  = head_bit(tx_aligned, lsb_first);
                        tx_sh_d = shift_out(tx_aligned, lsb_first);
                    end else begin
                        tx_sh_d = tx_aligned;
                    end
                end
            end
            S_SETUP: begin
                sclk_d = cfg_q.cpol;
                if (tick) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    lead_d = ~lead_q;
                    if (lead_q) begin
                        if (!cfg_q.cpha) begin
                            rx_sh_d = shift_in(rx_sh_q, miso, cfg_q.lsb_first);
                        end else begin
                            mosi_d  = head_bit(tx_sh_q, cfg_q.lsb_first);
                            tx_sh_d = shift_out(tx_sh_q, cfg_q.lsb_first);
                        end
                    end else begin
                        if (cfg_q.cpha) rx_sh_d = shift_in(rx_sh_q, miso, cfg_q.lsb_first);
                        if (bit_cnt_q == len_q - LW'(1)) begin
                            state_d = S_HOLD;
                            mosi_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + LW'(1);
                            if (!cfg_q.cpha) begin
                                mosi_d  = head_bit(tx_sh_q, cfg_q.lsb_first);
                                tx_sh_d = shift_out(tx_sh_q, cfg_q.lsb_first);
                            end
                        end
                    end
                end
            end
            S_HOLD: begin
                sclk_d = cfg_q.cpol;
                mosi_d = 1'b1;
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cs_n_d  = 1'b1;
                    // LSB-first bits were shifted in from the top; bring them down.
                    rx_data_d = cfg_q.lsb_first ? (rx_sh_q >> (LEN_MAX - len_q)) : rx_sh_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cfg_q     <= SPI_MODE0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            lead_q    <= 1'b1;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            lead_q    <= lead_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule
